pd_block_loader: RTL

PD_BLOCK_LOADER -- requirements
Module: PD_block_loader

---
 rtl/pd_block_loader_pkg.sv | 14 +
 rtl/pd_block_loader_byte_counter.sv | 40 ++++
 rtl/pd_block_loader.sv | 116 +++++++++++
 3 files changed

// File: rtl/pd_block_loader_pkg.sv
// Shared definitions for the PD header block loader: the FSM state encoding
// and the number of header+difficulty bytes written per load.
package pd_block_loader_pkg;

  localparam int PD_HEADER_BYTES = 112;
  localparam int PD_ADDR_W       = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pd_block_loader_byte_counter.sv
// Storage byte address counter: synchronous clear, count enable, and a
// terminal flag raised while the count sits on the last header address.
module pd_block_loader_byte_counter
  import pd_block_loader_pkg::*;
#(
  parameter int NUM_BYTES = PD_HEADER_BYTES,
  parameter int ADDR_W    = PD_ADDR_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              enable,
  output logic [ADDR_W-1:0] count,
  output logic              terminal
);

  logic [ADDR_W-1:0] count_q, count_d;

  // Compared as int so a NUM_BYTES that overflows ADDR_W never aliases a low address.
  assign terminal = (int'(count_q) == (NUM_BYTES - 1));
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !terminal) begin
      count_d = count_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pd_block_loader.sv
// Header byte loader: takes a valid/ready byte stream and writes each accepted
// byte to block storage at addresses 0..NUM_BYTES-1, one registered strobe per byte.
module pd_block_loader
  import pd_block_loader_pkg::*;
#(
  parameter int NUM_BYTES = PD_HEADER_BYTES,
  parameter int ADDR_W    = PD_ADDR_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              o_data_en,
  output logic [7:0]        o_data,
  output logic [ADDR_W-1:0] o_data_sel,
  output logic              busy,
  output logic              load_done,
  input  logic              done_ack
);

  state_e            state_q, state_d;
  logic              accept;
  logic              cnt_clear;
  logic              cnt_terminal;
  logic [ADDR_W-1:0] cnt;

  logic              data_en_q, data_en_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] data_sel_q, data_sel_d;

  pd_block_loader_byte_counter #(
    .NUM_BYTES (NUM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_byte_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (cnt_clear),
    .enable   (accept),
    .count    (cnt),
    .terminal (cnt_terminal)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (accept && cnt_terminal) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
        end else if (done_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_ready  = (state_q == ST_LOAD);
    busy      = (state_q == ST_LOAD);
    load_done = (state_q == ST_DONE);
  end

  // A byte arriving on the abort edge is dropped: no strobe, no count.
  always_comb begin
    accept    = rx_ready && rx_valid && !abort;
    cnt_clear = (start && (state_q != ST_LOAD)) || ((state_q == ST_LOAD) && abort);
  end

  always_comb begin
    data_en_d  = accept;
    data_d     = data_q;
    data_sel_d = data_sel_q;
    if (accept) begin
      data_d     = rx_byte;
      data_sel_d = cnt;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_en_q  <= 1'b0;
      data_q     <= '0;
      data_sel_q <= '0;
    end else begin
      data_en_q  <= data_en_d;
      data_q     <= data_d;
      data_sel_q <= data_sel_d;
    end
  end

  assign o_data_en  = data_en_q;
  assign o_data     = data_q;
  assign o_data_sel = data_sel_q;

endmodule
